// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// Pure declarations: no latency, no flow control.
package ifu_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] RV_NOP  = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: instruction memory read port, redirect input and decode valid/ready.
// Wires only; master is the fetch unit, slave is memory plus decode.
interface instr_fetch_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc
  );

endinterface

// File: rtl/ifu_fifo.sv
// Prefetch FIFO: synchronous write, head visible combinationally (0-cycle read, 1-cycle write-to-head).
// Refuses a push when full unless popping that cycle; flush overrides push and pop.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t wr_data,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~flush & (~full | pop);
  assign do_pop  = pop & ~flush & ~empty;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC + prefetch FIFO; head valid one cycle after its fetch, 1 instr/cycle. Full FIFO without pop stalls the PC.
// Redirect flushes and reloads the PC. Define IFU_PERF_CNT_EN for pop/stall counters.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  instr_fetch_unit_if.master        bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]               perf_fetch_cnt,
  output logic [31:0]               perf_stall_cnt
`endif
);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         fifo_full, fifo_empty;
  logic         push, pop;
  fetch_entry_t wr_entry, head_entry;
  logic         unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  assign bus.imem_addr = word_align(fetch_pc_q);
  assign bus.if_valid  = ~fifo_empty;
  assign bus.if_instr  = fifo_empty ? RV_NOP : head_entry.instr;
  assign bus.if_pc     = fifo_empty ? 32'h0 : head_entry.pc;

  assign pop  = bus.if_valid & bus.if_ready;
  assign push = ~bus.redirect_valid & (~fifo_full | pop);

  assign wr_entry.pc    = fetch_pc_q;
  assign wr_entry.instr = bus.imem_data;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) fetch_pc_d = word_align(bus.redirect_pc);
    else if (push)          fetch_pc_d = fetch_pc_q + PC_STEP;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fetch_pc_q <= RESET_PC;
    else          fetch_pc_q <= fetch_pc_d;
  end

  ifu_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (bus.redirect_valid),
    .wr_data (wr_entry),
    .head    (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  // A pop in a redirect cycle still counts: decode consumed that entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop)                          fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (bus.if_valid & ~bus.if_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random ready/redirect traffic,
// checked every cycle against a queue-based model of the fetch stream.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if ifb();

`ifdef IFU_PERF_CNT_EN
  logic [31:0] pf_cnt, ps_cnt;
`endif

  instr_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (ifb)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (pf_cnt),
    .perf_stall_cnt (ps_cnt)
`endif
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0) return 32'h0011_0233;
    if (a == 32'h4) return 32'h4011_02B3;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  assign ifb.imem_data = rom(ifb.imem_addr);

  int unsigned  n_cmp = 0;
  int unsigned  n_fail = 0;
  fetch_entry_t mq[$];
  logic [31:0]  m_fetch;
  logic [31:0]  m_fc, m_sc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic v;
    v = (mq.size() != 0);
    chk({tag, "_valid"}, {31'h0, ifb.if_valid}, {31'h0, v});
    chk({tag, "_pc"},    ifb.if_pc,    v ? mq[0].pc    : 32'h0);
    chk({tag, "_instr"}, ifb.if_instr, v ? mq[0].instr : 32'h0000_0013);
    chk({tag, "_addr"},  ifb.imem_addr, {m_fetch[31:2], 2'b00});
`ifdef IFU_PERF_CNT_EN
    chk({tag, "_pfetch"}, pf_cnt, m_fc);
    chk({tag, "_pstall"}, ps_cnt, m_sc);
`endif
  endtask

  // Asserts reset between clock edges, checks the immediate effect, releases on a falling edge.
  task automatic apply_reset(input string tag);
    ifb.if_ready       = 1'b0;
    ifb.redirect_valid = 1'b0;
    ifb.redirect_pc    = 32'h0;
    #2 reset_n = 1'b0;
    mq.delete();
    m_fetch = RST_PC;
    m_fc = 32'h0;
    m_sc = 32'h0;
    #1;
    check_model(tag);
    chk({tag, "_now_valid"}, {31'h0, ifb.if_valid}, 32'h0);
    chk({tag, "_now_addr"}, ifb.imem_addr, RST_PC);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic         pop, full;
    fetch_entry_t e;
    ifb.if_ready       = rdy;
    ifb.redirect_valid = rv;
    ifb.redirect_pc    = rpc;
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == DEPTH);
    if (pop) m_fc++;
    if ((mq.size() != 0) && !rdy) m_sc++;
    if (rv) begin
      mq.delete();
      m_fetch = {rpc[31:2], 2'b00};
    end else begin
      if (pop) mq.delete(0);
      if (!full || pop) begin
        e.pc    = m_fetch;
        e.instr = rom(m_fetch);
        mq.push_back(e);
        m_fetch = m_fetch + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    check_model("cyc");
  endtask

  initial begin
    apply_reset("rst");
    chk("rst_instr", ifb.if_instr, 32'h0000_0013);
    chk("rst_pc", ifb.if_pc, 32'h0);

    cycle(1'b1, 1'b0, 32'h0);
    chk("s1_pc", ifb.if_pc, 32'h0);
    chk("s1_instr", ifb.if_instr, 32'h0011_0233);
    cycle(1'b1, 1'b0, 32'h0);
    chk("s2_pc", ifb.if_pc, 32'h4);
    chk("s2_instr", ifb.if_instr, 32'h4011_02B3);

    apply_reset("rst2");
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      chk("bp_head", ifb.if_pc, 32'h0);
      if (i >= 1) chk("bp_addr", ifb.imem_addr, 32'h8);
    end
    cycle(1'b1, 1'b0, 32'h0);
    chk("rel_pc4", ifb.if_pc, 32'h4);
    cycle(1'b1, 1'b0, 32'h0);
    chk("rel_pc8", ifb.if_pc, 32'h8);
    cycle(1'b1, 1'b0, 32'h0);
    chk("rel_pc12", ifb.if_pc, 32'hC);

    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0017);
    chk("redir_valid", {31'h0, ifb.if_valid}, 32'h0);
    chk("redir_addr", ifb.imem_addr, 32'h14);
    cycle(1'b0, 1'b0, 32'h0);
    chk("redir_pc", ifb.if_pc, 32'h14);

    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    apply_reset("arst");

    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_flush", {31'h0, ifb.if_valid}, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("wrap_pc_hi", ifb.if_pc, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 32'h0);
    chk("wrap_pc_0", ifb.if_pc, 32'h0);

`ifdef IFU_PERF_CNT_EN
    apply_reset("perf_rst");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    chk("perf_fetch3", pf_cnt, 32'd3);
    chk("perf_stall2", ps_cnt, 32'd2);
`endif

    apply_reset("rnd_rst");
    for (int i = 0; i < 400; i++) begin
      logic        rdy, rv;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | {28'h0, rpc[3:0]};
      cycle(rdy, rv, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
